fetch_stage: RTL and testbench
==============================

Name: fetch_stage

Overview:
Instruction-fetch stage and IF/ID pipeline register for the 19-bit pipelined MIPS core. It holds the PC, addresses instruction memory, and latches the fetched word plus PC+1 into IF/ID. It obeys the stall and flush controls from the hazard detection unit and redirects on taken branches and jumps. It also keeps saturating stall/flush event counters for debug.

Parameters:
ADDR_W, 12, PC / instruction-memory address width in words
INST_W, 19, instruction width
CNT_W, 16, width of each debug event counter

Ports:
clk  in  1  core clock, rising edge
reset  in  1  asynchronous, active-high
imem_addr  out  ADDR_W  instruction-memory word address (= pc)
imem_data  in  INST_W  instruction word, combinational read of imem_addr
pc_writebar  in  1  1 = hold PC this cycle
IF_ID_loadbar  in  1  1 = hold IF/ID register this cycle
IF_ID_flush  in  1  1 = load NOP into IF/ID this cycle
do_branch  in  1  branch in ID is taken
branch_target  in  ADDR_W  target for taken branch
jump_target  in  ADDR_W  target for jump (opcode[18:16]=111 in ID)
IF_ID_instruction  out  INST_W  registered instruction to ID
IF_ID_pc  out  ADDR_W  registered PC+1 of that instruction
IF_ID_valid  out  1  0 when IF/ID holds a flushed or reset bubble
stall_count  out  CNT_W  cycles with pc_writebar=1 and no redirect
flush_count  out  CNT_W  cycles with IF_ID_flush=1

Behaviour:
- Reset (async, any time): pc=0, IF_ID_instruction=0 (NOP), IF_ID_pc=0, IF_ID_valid=0, both counters=0. The first fetch is address 0 on the first edge after reset deasserts.
- imem_addr = pc, combinational. The fetched word is imem_data in the same cycle.
- Redirect: jump_req = (IF_ID_instruction[18:16]==3'b111) && IF_ID_valid. On a clock edge:
  - do_branch=1: pc <= branch_target.
  - else jump_req: pc <= jump_target.
  - else pc_writebar=1: pc holds.
  - else pc <= pc+1, modulo 2^ADDR_W, so it wraps from all-ones to 0.
- A redirect overrides pc_writebar. do_branch takes priority over jump_req when both are set.
- IF/ID update, priority order:
  - IF_ID_flush=1: IF_ID_instruction<=0, IF_ID_pc<=0, IF_ID_valid<=0.
  - else IF_ID_loadbar=1: all three hold.
  - else: IF_ID_instruction<=imem_data, IF_ID_pc<=pc+1 (wrapped), IF_ID_valid<=1.
- Flush beats loadbar when both are asserted.
- Redirect alone does not clear IF/ID. The hazard unit asserts IF_ID_flush for branch/jump, and this block relies on that.
- Counters:
  - stall_count increments on every edge with pc_writebar=1, do_branch=0 and jump_req=0.
  - flush_count increments on every edge with IF_ID_flush=1.
  - Both saturate at 2^CNT_W-1.
- Latency: one cycle from imem_data to IF_ID_instruction. A redirect target is fetched in the cycle after the edge.
- Controls are sampled only at rising edges. Glitches between edges have no effect. No X propagates from unasserted inputs.

Test Plan:
- Reset then 4 free-running cycles, imem[k]=k+0x100 -> pc 0,1,2,3,4. IF_ID_instruction 0x100..0x103 with IF_ID_pc 1..4. valid=1 from the first edge.
- pc_writebar=1 and IF_ID_loadbar=1 for 2 cycles at pc=5 -> pc stays 5, IF/ID holds, stall_count=2. Release -> pc=6 next edge.
- do_branch=1, branch_target=0x3A0, with IF_ID_flush=1 -> pc=0x3A0, IF_ID_instruction=0, valid=0, flush_count+1. Next edge latches imem[0x3A0].
- IF/ID holds opcode 111 (valid), jump_target=0x010, pc_writebar=1 -> pc=0x010 (redirect beats stall), stall_count unchanged.
- pc=0xFFF free-running -> pc=0x000, IF_ID_pc=0x000.
- reset asserted mid-stall at pc=0x123, between clock edges -> outputs zero immediately. Counters reach 2^CNT_W-1 and stay there under continuous stall.

Source files
------------

// File: rtl/fetch_stage.sv
// Instruction-fetch stage with IF/ID pipeline register for the 19-bit MIPS core.
// Holds the PC, handles branch/jump redirects, stall/flush, and debug counters.
module fetch_stage #(
    parameter int ADDR_W = 12,
    parameter int INST_W = 19,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [INST_W-1:0] imem_data,
    input  logic              pc_writebar,
    input  logic              IF_ID_loadbar,
    input  logic              IF_ID_flush,
    input  logic              do_branch,
    input  logic [ADDR_W-1:0] branch_target,
    input  logic [ADDR_W-1:0] jump_target,
    output logic [INST_W-1:0] IF_ID_instruction,
    output logic [ADDR_W-1:0] IF_ID_pc,
    output logic              IF_ID_valid,
    output logic [CNT_W-1:0]  stall_count,
    output logic [CNT_W-1:0]  flush_count
);

    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] pc_plus1;
    logic [INST_W-1:0] ins_q, ins_d;
    logic [ADDR_W-1:0] ipc_q, ipc_d;
    logic              val_q, val_d;
    logic [CNT_W-1:0]  stall_q, stall_d;
    logic [CNT_W-1:0]  flush_q, flush_d;
    logic              jump_req;
    logic              stall_ev;

    // Wraps naturally at the PC width.
    assign pc_plus1 = pc_q + {{(ADDR_W-1){1'b0}}, 1'b1};
    // Jump opcode sits in the top three bits of a live IF/ID word.
    assign jump_req = (ins_q[INST_W-1:INST_W-3] == 3'b111) && val_q;
    // A stall that a redirect overrides is not counted.
    assign stall_ev = pc_writebar && !do_branch && !jump_req;

    // Next PC: branch beats jump, any redirect beats the stall hold.
    always_comb begin
        pc_d = pc_plus1;
        if (do_branch) begin
            pc_d = branch_target;
        end else if (jump_req) begin
            pc_d = jump_target;
        end else if (pc_writebar) begin
            pc_d = pc_q;
        end
    end

    // IF/ID next state: flush loads a NOP bubble and beats loadbar.
    always_comb begin
        ins_d = ins_q;
        ipc_d = ipc_q;
        val_d = val_q;
        if (IF_ID_flush) begin
            ins_d = '0;
            ipc_d = '0;
            val_d = 1'b0;
        end else if (!IF_ID_loadbar) begin
            ins_d = imem_data;
            ipc_d = pc_plus1;
            val_d = 1'b1;
        end
    end

    // Saturating debug event counters.
    always_comb begin
        stall_d = stall_q;
        flush_d = flush_q;
        if (stall_ev && (stall_q != {CNT_W{1'b1}})) begin
            stall_d = stall_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
        if (IF_ID_flush && (flush_q != {CNT_W{1'b1}})) begin
            flush_d = flush_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    // PC register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q <= '0;
        end else begin
            pc_q <= pc_d;
        end
    end

    // IF/ID pipeline register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ins_q <= '0;
            ipc_q <= '0;
            val_q <= 1'b0;
        end else begin
            ins_q <= ins_d;
            ipc_q <= ipc_d;
            val_q <= val_d;
        end
    end

    // Debug counter registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            stall_q <= stall_d;
            flush_q <= flush_d;
        end
    end

    assign imem_addr         = pc_q;
    assign IF_ID_instruction = ins_q;
    assign IF_ID_pc          = ipc_q;
    assign IF_ID_valid       = val_q;
    assign stall_count       = stall_q;
    assign flush_count       = flush_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Testbench for fetch_stage: directed steps with an expected-value queue
// filled from a small behavioural model and drained after each clock edge.
module tb_fetch_stage;

    localparam int AW = 12;
    localparam int IW = 19;
    localparam int CW = 8;
    localparam logic [CW-1:0] CMAX = {CW{1'b1}};

    typedef struct {
        logic [AW-1:0] pc;
        logic [IW-1:0] ins;
        logic [AW-1:0] ipc;
        logic          val;
        logic [CW-1:0] sc;
        logic [CW-1:0] fc;
    } exp_t;

    logic          clk = 1'b0;
    logic          reset;
    logic [AW-1:0] imem_addr;
    logic [IW-1:0] imem_data;
    logic          pc_writebar;
    logic          IF_ID_loadbar;
    logic          IF_ID_flush;
    logic          do_branch;
    logic [AW-1:0] branch_target;
    logic [AW-1:0] jump_target;
    logic [IW-1:0] IF_ID_instruction;
    logic [AW-1:0] IF_ID_pc;
    logic          IF_ID_valid;
    logic [CW-1:0] stall_count;
    logic [CW-1:0] flush_count;

    logic [IW-1:0] mem [0:(1<<AW)-1];
    exp_t          q[$];

    logic [AW-1:0] m_pc;
    logic [IW-1:0] m_ins;
    logic [AW-1:0] m_ipc;
    logic          m_val;
    logic [CW-1:0] m_sc;
    logic [CW-1:0] m_fc;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    assign imem_data = mem[imem_addr];

    fetch_stage #(.ADDR_W(AW), .INST_W(IW), .CNT_W(CW)) dut (
        .clk              (clk),
        .reset            (reset),
        .imem_addr        (imem_addr),
        .imem_data        (imem_data),
        .pc_writebar      (pc_writebar),
        .IF_ID_loadbar    (IF_ID_loadbar),
        .IF_ID_flush      (IF_ID_flush),
        .do_branch        (do_branch),
        .branch_target    (branch_target),
        .jump_target      (jump_target),
        .IF_ID_instruction(IF_ID_instruction),
        .IF_ID_pc         (IF_ID_pc),
        .IF_ID_valid      (IF_ID_valid),
        .stall_count      (stall_count),
        .flush_count      (flush_count)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_pc  = '0;
        m_ins = '0;
        m_ipc = '0;
        m_val = 1'b0;
        m_sc  = '0;
        m_fc  = '0;
    endtask

    // Model one edge from the current inputs, queue it, clock, compare.
    task automatic step();
        exp_t          e;
        exp_t          g;
        logic          jr;
        logic [AW-1:0] npc;
        jr = (m_ins[18:16] == 3'b111) && m_val;
        if (do_branch)        npc = branch_target;
        else if (jr)          npc = jump_target;
        else if (pc_writebar) npc = m_pc;
        else                  npc = m_pc + 1'b1;
        if (pc_writebar && !do_branch && !jr && m_sc != CMAX) m_sc = m_sc + 1'b1;
        if (IF_ID_flush && m_fc != CMAX) m_fc = m_fc + 1'b1;
        if (IF_ID_flush) begin
            m_ins = '0; m_ipc = '0; m_val = 1'b0;
        end else if (!IF_ID_loadbar) begin
            m_ins = mem[m_pc]; m_ipc = m_pc + 1'b1; m_val = 1'b1;
        end
        m_pc = npc;
        e.pc = m_pc; e.ins = m_ins; e.ipc = m_ipc;
        e.val = m_val; e.sc = m_sc; e.fc = m_fc;
        q.push_back(e);
        @(posedge clk);
        #1;
        g = q.pop_front();
        chk("pc",    32'(imem_addr),         32'(g.pc));
        chk("ins",   32'(IF_ID_instruction), 32'(g.ins));
        chk("ipc",   32'(IF_ID_pc),          32'(g.ipc));
        chk("valid", 32'(IF_ID_valid),       32'(g.val));
        chk("stall", 32'(stall_count),       32'(g.sc));
        chk("flush", 32'(flush_count),       32'(g.fc));
    endtask

    task automatic idle();
        pc_writebar   = 1'b0;
        IF_ID_loadbar = 1'b0;
        IF_ID_flush   = 1'b0;
        do_branch     = 1'b0;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_pc"},    32'(imem_addr),         32'h0);
        chk({tag, "_ins"},   32'(IF_ID_instruction), 32'h0);
        chk({tag, "_ipc"},   32'(IF_ID_pc),          32'h0);
        chk({tag, "_valid"}, 32'(IF_ID_valid),       32'h0);
        chk({tag, "_stall"}, 32'(stall_count),       32'h0);
        chk({tag, "_flush"}, 32'(flush_count),       32'h0);
    endtask

    initial begin
        for (int k = 0; k < (1 << AW); k++) mem[k] = IW'(k + 'h100);
        mem[12'h3A0] = {3'b111, 16'h0042};
        idle();
        branch_target = '0;
        jump_target   = '0;
        reset = 1'b1;
        model_reset();
        #3;
        chk_zero("rst");
        @(negedge clk);
        reset = 1'b0;

        // Free-running fetch of addresses 0..3.
        for (int i = 0; i < 4; i++) step();
        chk("run_ins", 32'(IF_ID_instruction), 32'h103);
        chk("run_ipc", 32'(IF_ID_pc),          32'h4);
        chk("run_pc",  32'(imem_addr),         32'h4);
        step();

        // Stall PC and IF/ID for two cycles at pc=5.
        pc_writebar = 1'b1; IF_ID_loadbar = 1'b1;
        step(); step();
        chk("stall_pc",  32'(imem_addr),         32'h5);
        chk("stall_ins", 32'(IF_ID_instruction), 32'h104);
        chk("stall_cnt", 32'(stall_count),       32'h2);
        idle();
        step();
        chk("rel_pc", 32'(imem_addr), 32'h6);

        // Taken branch with flush.
        do_branch = 1'b1; branch_target = 12'h3A0; IF_ID_flush = 1'b1;
        step();
        chk("br_pc",    32'(imem_addr),   32'h3A0);
        chk("br_valid", 32'(IF_ID_valid), 32'h0);
        chk("br_fc",    32'(flush_count), 32'h1);
        idle();
        step();
        chk("br_ins", 32'(IF_ID_instruction), 32'h70042);

        // Jump in IF/ID beats a PC stall; stall not counted.
        jump_target = 12'h010; pc_writebar = 1'b1;
        step();
        chk("jmp_pc", 32'(imem_addr),   32'h010);
        chk("jmp_sc", 32'(stall_count), 32'h2);
        idle();
        step();

        // Flush beats loadbar.
        IF_ID_flush = 1'b1; IF_ID_loadbar = 1'b1;
        step();
        chk("fl_valid", 32'(IF_ID_valid), 32'h0);
        idle();
        step();

        // PC wrap from all-ones to zero.
        do_branch = 1'b1; branch_target = 12'hFFE;
        step();
        idle();
        step(); step();
        chk("wrap_pc",  32'(imem_addr), 32'h000);
        chk("wrap_ipc", 32'(IF_ID_pc),  32'h000);

        // Counter saturation under continuous stall and flush.
        pc_writebar = 1'b1; IF_ID_flush = 1'b1;
        for (int i = 0; i < (1 << CW) + 4; i++) step();
        chk("sat_sc", 32'(stall_count), 32'(CMAX));
        chk("sat_fc", 32'(flush_count), 32'(CMAX));
        idle();

        // Async reset mid-stall at pc=0x123.
        do_branch = 1'b1; branch_target = 12'h123;
        step();
        idle();
        pc_writebar = 1'b1;
        step();
        chk("pre_rst_pc", 32'(imem_addr), 32'h123);
        @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        chk_zero("arst");
        model_reset();
        @(negedge clk);
        reset = 1'b0;
        idle();
        step();
        chk("post_rst_ins", 32'(IF_ID_instruction), 32'h100);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
